rgb888_to_yuv444: RTL and testbench

Pipelined colour-space converter that sits directly upstream of the YUV444→YUV422 packer. It takes sensor/ISP RGB888 pixels with FrameValid/LineValid framing and produces BT.601 full-range YUV444 with the same framing. The framing is delayed to match the datapath latency, so the downstream packer's FrameValid_i, LineValid_i and Y/U/V_444_i connect directly. It also provides per-line pixel and per-frame line counters for debug and stream checking.

---
 rtl/rgb888_to_yuv444_if.sv | 26 ++
 rtl/rgb888_to_yuv444.sv | 108 ++++++++++
 tb/tb_rgb888_to_yuv444.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rgb888_to_yuv444_if.sv
// rgb888_to_yuv444_if: RGB888 pixel stream in, framed YUV444 stream plus debug counters out.
interface rgb888_to_yuv444_if #(
    parameter int PIX_CNT_W  = 12,
    parameter int LINE_CNT_W = 11
);
    logic                  FrameValid_i;
    logic                  LineValid_i;
    logic [7:0]            R_i;
    logic [7:0]            G_i;
    logic [7:0]            B_i;
    logic                  FrameValid_o;
    logic                  LineValid_o;
    logic [7:0]            Y_444_o;
    logic [7:0]            U_444_o;
    logic [7:0]            V_444_o;
    logic [PIX_CNT_W-1:0]  PixCnt_o;
    logic [LINE_CNT_W-1:0] LineCnt_o;
    modport slave (
        input  FrameValid_i, LineValid_i, R_i, G_i, B_i,
        output FrameValid_o, LineValid_o, Y_444_o, U_444_o, V_444_o, PixCnt_o, LineCnt_o
    );
    modport master (
        output FrameValid_i, LineValid_i, R_i, G_i, B_i,
        input  FrameValid_o, LineValid_o, Y_444_o, U_444_o, V_444_o, PixCnt_o, LineCnt_o
    );
endinterface

// File: rtl/rgb888_to_yuv444.sv
// rgb888_to_yuv444: 3-stage BT.601 RGB888->YUV444 converter with delayed framing and saturating counters.
// Define RGB2YUV_STUDIO_RANGE_EN for limited-range (studio swing) coefficients; full range otherwise.
module rgb888_to_yuv444 #(
    parameter int PIX_CNT_W  = 12,
    parameter int LINE_CNT_W = 11
) (
    input logic clk_i,
    input logic rst_i,
    rgb888_to_yuv444_if.slave bus
);
`ifdef RGB2YUV_STUDIO_RANGE_EN
    localparam logic [15:0] KYR = 16'd66,  KYG = 16'd129, KYB = 16'd25;
    localparam logic [15:0] KUR = 16'd38,  KUG = 16'd74,  KUB = 16'd112;
    localparam logic [15:0] KVR = 16'd112, KVG = 16'd94,  KVB = 16'd18;
    localparam logic signed [17:0] Y_OFS = 18'sd16;
`else
    localparam logic [15:0] KYR = 16'd77,  KYG = 16'd150, KYB = 16'd29;
    localparam logic [15:0] KUR = 16'd43,  KUG = 16'd85,  KUB = 16'd128;
    localparam logic [15:0] KVR = 16'd128, KVG = 16'd107, KVB = 16'd21;
    localparam logic signed [17:0] Y_OFS = 18'sd0;
`endif
    localparam logic signed [17:0] C_OFS = 18'sd128;
    localparam logic signed [17:0] RND   = 18'sd128;

    function automatic logic signed [17:0] ext(input logic [15:0] x);
        return $signed({2'b00, x});
    endfunction

    function automatic logic [7:0] clamp(input logic signed [17:0] s, input logic signed [17:0] ofs);
        logic signed [17:0] t;
        t = (s >>> 8) + ofs;
        return t < 18'sd0 ? 8'd0 : t > 18'sd255 ? 8'd255 : t[7:0];
    endfunction

    logic [8:0][15:0]        p;
    logic                    fv1, v1;
    logic signed [17:0]      sy, su, sv;
    logic                    fv2, v2;
    logic                    fv3, v3;
    logic [7:0]              y3, u3, v3_c;
    logic [PIX_CNT_W-1:0]    pix;
    logic [LINE_CNT_W-1:0]   line;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p   <= '0;
            fv1 <= 1'b0;
            v1  <= 1'b0;
        end else begin
            p[0] <= 16'(bus.R_i) * KYR;
            p[1] <= 16'(bus.G_i) * KYG;
            p[2] <= 16'(bus.B_i) * KYB;
            p[3] <= 16'(bus.R_i) * KUR;
            p[4] <= 16'(bus.G_i) * KUG;
            p[5] <= 16'(bus.B_i) * KUB;
            p[6] <= 16'(bus.R_i) * KVR;
            p[7] <= 16'(bus.G_i) * KVG;
            p[8] <= 16'(bus.B_i) * KVB;
            fv1  <= bus.FrameValid_i;
            v1   <= bus.FrameValid_i & bus.LineValid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sy  <= '0;
            su  <= '0;
            sv  <= '0;
            fv2 <= 1'b0;
            v2  <= 1'b0;
        end else begin
            sy  <= ext(p[0]) + ext(p[1]) + ext(p[2]) + RND;
            su  <= ext(p[5]) - ext(p[3]) - ext(p[4]) + RND;
            sv  <= ext(p[6]) - ext(p[7]) - ext(p[8]) + RND;
            fv2 <= fv1;
            v2  <= v1;
        end
    end

    // counters are updated from the stage-2 flags so they line up with the stage-3 pixel
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fv3  <= 1'b0;
            v3   <= 1'b0;
            y3   <= '0;
            u3   <= '0;
            v3_c <= '0;
            pix  <= '0;
            line <= '0;
        end else begin
            fv3  <= fv2;
            v3   <= v2;
            y3   <= v2 ? clamp(sy, Y_OFS) : 8'd0;
            u3   <= v2 ? clamp(su, C_OFS) : 8'd0;
            v3_c <= v2 ? clamp(sv, C_OFS) : 8'd0;
            pix  <= !v2 || !v3 ? '0 : &pix ? pix : pix + PIX_CNT_W'(1);
            line <= !fv2 ? '0 : v3 && !v2 && !(&line) ? line + LINE_CNT_W'(1) : line;
        end
    end

    assign bus.FrameValid_o = fv3;
    assign bus.LineValid_o  = v3;
    assign bus.Y_444_o      = y3;
    assign bus.U_444_o      = u3;
    assign bus.V_444_o      = v3_c;
    assign bus.PixCnt_o     = pix;
    assign bus.LineCnt_o    = line;
endmodule

// File: tb/tb_rgb888_to_yuv444.sv
// tb_rgb888_to_yuv444: scoreboard bench; default build plus a PIX_CNT_W=3 instance for counter saturation.
module tb_rgb888_to_yuv444;
    typedef struct packed {
        logic        fv;
        logic        lv;
        logic [7:0]  y;
        logic [7:0]  u;
        logic [7:0]  v;
        logic [11:0] pix;
        logic [10:0] line;
    } rec_t;

    logic clk_i, rst_i;
    rec_t exp_q[$];
    int   n_chk, n_err;
    int   m_pix, m_line;
    logic m_prev;

    rgb888_to_yuv444_if bus();
    rgb888_to_yuv444_if #(.PIX_CNT_W(3)) bus3();

    rgb888_to_yuv444 dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));
    rgb888_to_yuv444 #(.PIX_CNT_W(3)) dut3 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus3.slave));

    assign bus3.FrameValid_i = bus.FrameValid_i;
    assign bus3.LineValid_i  = bus.LineValid_i;
    assign bus3.R_i          = bus.R_i;
    assign bus3.G_i          = bus.G_i;
    assign bus3.B_i          = bus.B_i;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] clip(input int x);
        return x < 0 ? 8'd0 : x > 255 ? 8'd255 : 8'(x);
    endfunction

    function automatic logic [23:0] ref_yuv(input int r, input int g, input int b);
        int y, u, v;
`ifdef RGB2YUV_STUDIO_RANGE_EN
        y = ((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16;
        u = ((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128;
        v = ((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128;
`else
        y = (77 * r + 150 * g + 29 * b + 128) >>> 8;
        u = ((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128;
        v = ((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128;
`endif
        return {clip(y), clip(u), clip(v)};
    endfunction

    // one input cycle: expected output record is queued, it emerges three clocks later
    task automatic drive(input logic fv, input logic lv, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic [23:0] yuv);
        rec_t e;
        logic valid;
        valid = fv & lv;
        bus.FrameValid_i = fv;
        bus.LineValid_i  = lv;
        bus.R_i = r;
        bus.G_i = g;
        bus.B_i = b;
        m_line = !fv ? 0 : (m_prev && !valid) ? m_line + 1 : m_line;
        m_pix  = !valid ? 0 : m_prev ? m_pix + 1 : 0;
        m_prev = valid;
        e.fv   = fv;
        e.lv   = valid;
        e.y    = valid ? yuv[23:16] : 8'd0;
        e.u    = valid ? yuv[15:8] : 8'd0;
        e.v    = valid ? yuv[7:0] : 8'd0;
        e.pix  = 12'(m_pix);
        e.line = 11'(m_line);
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic px(input logic fv, input logic lv, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        drive(fv, lv, r, g, b, ref_yuv(r, g, b));
    endtask

    task automatic pk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic [23:0] k);
`ifdef RGB2YUV_STUDIO_RANGE_EN
        drive(1'b1, 1'b1, r, g, b, ref_yuv(r, g, b));
`else
        drive(1'b1, 1'b1, r, g, b, k);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) px(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic gap(input int n);
        repeat (n) px(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic rnd_line(input int n);
        repeat (n) px(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // pipeline is flushed to zero by the reset edge, so three zero records stand in for it
    task automatic do_reset();
        rst_i = 1'b1;
        exp_q.push_back('0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
        m_prev = 1'b0;
        m_pix  = 0;
        m_line = 0;
    endtask

    always @(negedge clk_i) begin
        rec_t e;
        if (exp_q.size() > 3) begin
            e = exp_q.pop_front();
            check("frame_valid", bus.FrameValid_o, e.fv);
            check("line_valid", bus.LineValid_o, e.lv);
            check("y", bus.Y_444_o, e.y);
            check("u", bus.U_444_o, e.u);
            check("v", bus.V_444_o, e.v);
            check("pix_cnt", bus.PixCnt_o, e.pix);
            check("line_cnt", bus.LineCnt_o, e.line);
            check("pix_cnt_w3", bus3.PixCnt_o, e.pix > 12'd7 ? 12'd7 : e.pix);
        end
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        m_prev = 1'b0;
        m_pix = 0;
        m_line = 0;
        rst_i = 1'b1;
        bus.FrameValid_i = 1'b0;
        bus.LineValid_i = 1'b0;
        bus.R_i = 8'd0;
        bus.G_i = 8'd0;
        bus.B_i = 8'd0;
        do_reset();
        idle(2);
        px(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        pk(8'd0, 8'd0, 8'd0, {8'd0, 8'd128, 8'd128});
        pk(8'd255, 8'd255, 8'd255, {8'd255, 8'd128, 8'd128});
        pk(8'd255, 8'd0, 8'd0, {8'd77, 8'd85, 8'd255});
        pk(8'd0, 8'd0, 8'd255, {8'd29, 8'd255, 8'd107});
        gap(2);
        pk(8'd0, 8'd255, 8'd0, {8'd149, 8'd43, 8'd21});
        gap(1);
        idle(3);
        px(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int l = 0; l < 3; l++) begin
            rnd_line(5);
            if (l < 2) gap(2);
        end
        idle(3);
        repeat (4) px(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        idle(3);
        gap(1);
        rnd_line(1);
        gap(1);
        rnd_line(1);
        gap(2);
        idle(3);
        gap(1);
        rnd_line(5);
        do_reset();
        rnd_line(4);
        gap(1);
        idle(3);
        gap(1);
        rnd_line(10);
        gap(2);
        rnd_line(6);
        repeat (2) px(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        idle(3);
        for (int f = 0; f < 3; f++) begin
            gap(1);
            for (int l = 0; l < 4; l++) begin
                rnd_line(1 + int'($urandom_range(8)));
                gap(1 + int'($urandom_range(2)));
            end
            idle(1 + int'($urandom_range(2)));
        end
        idle(5);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
